// File: rtl/tile_bg_saver.sv
// Captures a TILE_W x TILE_H frame-buffer region into a tile RAM and replays it as VGA pixel writes.
// Optional TILE_CLIP_EN: suppress plots and zero captured colour for pixels beyond the 160x120 screen.
module tile_bg_saver #(
  parameter int TILE_W   = 20,
  parameter int TILE_H   = 20,
  parameter int COLOUR_W = 9
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_save,
  input  logic                start_restore,
  input  logic [7:0]          base_x,
  input  logic [6:0]          base_y,
  output logic [7:0]          fb_rd_x,
  output logic [6:0]          fb_rd_y,
  input  logic [COLOUR_W-1:0] fb_rd_colour,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int N   = TILE_W * TILE_H;
  localparam int AW  = $clog2(N);
  localparam int CXW = $clog2(TILE_W);
  localparam int CYW = $clog2(TILE_H);
`ifdef TILE_CLIP_EN
  localparam int XSW = 9;
  localparam int YSW = 8;
`else
  localparam int XSW = 8;
  localparam int YSW = 7;
`endif

  typedef enum logic [2:0] {
    IDLE, SAVE, SAVE_FLUSH, RESTORE, RESTORE_FLUSH, DONE
  } state_t;

  state_t state, state_n;

  logic [CXW-1:0]      cx, cx_n;
  logic [CYW-1:0]      cy, cy_n;
  logic                cx_last, cy_last, tile_last;
  logic [7:0]          bx_q;
  logic [6:0]          by_q;
  logic [AW-1:0]       addr;
  logic [XSW-1:0]      sx;
  logic [YSW-1:0]      sy;
  logic                clip;
  logic                wr_en, wr_clip;
  logic [AW-1:0]       wr_addr;
  logic [COLOUR_W-1:0] ram [0:N-1];

  assign cx_last   = (cx == CXW'(TILE_W - 1));
  assign cy_last   = (cy == CYW'(TILE_H - 1));
  assign tile_last = cx_last && cy_last;
  assign cx_n      = cx_last ? '0 : cx + 1'b1;
  assign cy_n      = cx_last ? (cy_last ? '0 : cy + 1'b1) : cy;
  assign addr      = AW'(cy) * AW'(TILE_W) + AW'(cx);

  // Sums carry one extra bit in the clipping build so overflow counts as off-screen.
  assign sx = XSW'(bx_q) + XSW'(cx);
  assign sy = YSW'(by_q) + YSW'(cy);
`ifdef TILE_CLIP_EN
  assign clip = (sx > XSW'(159)) || (sy > YSW'(119));
`else
  assign clip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start_save)         state_n = SAVE;
        else if (start_restore) state_n = RESTORE;
      end
      SAVE: begin
        busy = 1'b1;
        if (tile_last) state_n = SAVE_FLUSH;
      end
      SAVE_FLUSH: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      RESTORE: begin
        busy = 1'b1;
        if (tile_last) state_n = RESTORE_FLUSH;
      end
      RESTORE_FLUSH: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cx      <= '0;
      cy      <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      fb_rd_x <= '0;
      fb_rd_y <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      wr_en   <= 1'b0;
      wr_clip <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_en <= 1'b0;
      plot  <= 1'b0;
      case (state)
        IDLE: begin
          cx <= '0;
          cy <= '0;
          if (start_save || start_restore) begin
            bx_q <= base_x;
            by_q <= base_y;
          end
          if (start_save) begin
            fb_rd_x <= base_x;
            fb_rd_y <= base_y;
          end
        end
        SAVE: begin
          cx <= cx_n;
          cy <= cy_n;
          if (!tile_last) begin
            fb_rd_x <= bx_q + 8'(cx_n);
            fb_rd_y <= by_q + 7'(cy_n);
          end
          // Read data returns a cycle later, so the write address trails by one.
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_clip <= clip;
        end
        RESTORE: begin
          cx     <= cx_n;
          cy     <= cy_n;
          x      <= sx[7:0];
          y      <= sy[6:0];
          colour <= ram[addr];
          plot   <= !clip;
        end
        default: ;
      endcase
    end
  end

  // Tile RAM is deliberately left unreset so a restore after reset still has the saved tile.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_clip ? '0 : fb_rd_colour;
  end

endmodule

// File: tb/tb_tile_bg_saver.sv
// Randomised directed bench for tile_bg_saver with a coordinate-level reference model.
module tb_tile_bg_saver;

`ifdef TILE_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start_save = 1'b0;
  logic       start_restore = 1'b0;
  logic [7:0] base_x = '0;
  logic [6:0] base_y = '0;
  logic [7:0] fb_rd_x;
  logic [6:0] fb_rd_y;
  logic [8:0] fb_rd_colour = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [8:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int         n_assert = 0;
  int         n_fail = 0;
  logic [8:0] salt = '0;
  logic [8:0] mem_model [400];

  tile_bg_saver dut (
    .clk(clk), .resetn(resetn), .start_save(start_save), .start_restore(start_restore),
    .base_x(base_x), .base_y(base_y), .fb_rd_x(fb_rd_x), .fb_rd_y(fb_rd_y),
    .fb_rd_colour(fb_rd_colour), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] fbf(input logic [7:0] px, input logic [6:0] py);
    return {py[2:0], px[5:0]} ^ salt;
  endfunction

  // Frame buffer answers one cycle after the address is presented.
  always @(posedge clk) fb_rd_colour <= fbf(fb_rd_x, fb_rd_y);

  function automatic bit off_screen(input int ax, input int ay);
    return CLIP_ON && (ax > 159 || ay > 119);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".fb_rd_x"}, 32'(fb_rd_x), 0);
    check({tag, ".fb_rd_y"}, 32'(fb_rd_y), 0);
    check({tag, ".x"}, 32'(x), 0);
    check({tag, ".y"}, 32'(y), 0);
    check({tag, ".colour"}, 32'(colour), 0);
    check({tag, ".plot"}, 32'(plot), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE (cycle 403, or just after a reset).
  task automatic run_op(input bit do_save, input bit do_restore, input int bx, input int by,
                        input int inject_k, input int reset_k);
    int  plots = 0;
    int  exp_plots = 0;
    int  dones = 0;
    bit  aborted = 0;
    int  i, ax, ay;
    bit  exp_plot;
    start_save    = do_save;
    start_restore = do_restore;
    base_x        = 8'(bx);
    base_y        = 7'(by);
    @(posedge clk);
    #1;
    start_save    = 1'b0;
    start_restore = 1'b0;
    base_x        = 8'($urandom);
    base_y        = 7'($urandom);
    for (int k = 1; k <= 403; k++) begin
      @(negedge clk);
      if (reset_k > 0 && k == reset_k + 1) begin
        check_all_zero("reset_mid");
        resetn  = 1'b1;
        aborted = 1;
        break;
      end
      check("busy", 32'(busy), 32'(k <= 401));
      check("done", 32'(done), 32'(k == 402));
      if (done) dones++;
      if (do_save) begin
        check("save_plot", 32'(plot), 0);
        if (k <= 400) begin
          i = k - 1;
          check("fb_rd_x", 32'(fb_rd_x), 32'((bx + i % 20) % 256));
          check("fb_rd_y", 32'(fb_rd_y), 32'((by + i / 20) % 128));
        end
      end else begin
        exp_plot = 0;
        if (k >= 2 && k <= 401) begin
          i  = k - 2;
          ax = bx + i % 20;
          ay = by + i / 20;
          exp_plot = !off_screen(ax, ay);
        end
        if (exp_plot) exp_plots++;
        check("plot", 32'(plot), 32'(exp_plot));
        if (plot) plots++;
        if (exp_plot) begin
          check("x", 32'(x), 32'(ax % 256));
          check("y", 32'(y), 32'(ay % 128));
          check("colour", 32'(colour), 32'(mem_model[i]));
        end
      end
      if (k == inject_k)     start_restore = 1'b1;
      if (k == inject_k + 1) start_restore = 1'b0;
      if (k == reset_k)      resetn = 1'b0;
    end
    if (!aborted) begin
      check("done_count", 32'(dones), 1);
      if (do_save) begin
        for (int j = 0; j < 400; j++) begin
          ax = bx + j % 20;
          ay = by + j / 20;
          mem_model[j] = off_screen(ax, ay) ? 9'd0 : fbf(8'(ax), 7'(ay));
        end
      end else begin
        check("plot_count", 32'(plots), 32'(exp_plots));
      end
    end
  endtask

  initial begin
    int rx, ry;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);

    salt = '0;
    run_op(1, 0, 40, 30, 0, 0);
    run_op(0, 1, 40, 30, 0, 0);

    salt = 9'($urandom);
    rx = $urandom_range(0, 255);
    ry = $urandom_range(0, 127);
    run_op(1, 1, rx, ry, 0, 0);
    run_op(0, 1, rx, ry, 0, 0);

    salt = 9'($urandom);
    rx = $urandom_range(0, 140);
    ry = $urandom_range(0, 100);
    run_op(1, 0, rx, ry, 100, 0);
    run_op(0, 1, $urandom_range(0, 255), $urandom_range(0, 127), 0, 0);

    salt = 9'($urandom);
    run_op(1, 0, $urandom_range(0, 255), $urandom_range(0, 127), 0, 200);
    rx = $urandom_range(0, 255);
    ry = $urandom_range(0, 127);
    run_op(1, 0, rx, ry, 0, 0);
    run_op(0, 1, rx, ry, 0, 0);

    salt = 9'($urandom);
    run_op(1, 0, 150, 110, 0, 0);
    run_op(0, 1, 150, 110, 0, 0);

    for (int n = 0; n < 2; n++) begin
      salt = 9'($urandom);
      run_op(1, 0, $urandom_range(0, 255), $urandom_range(0, 127), 0, 0);
      run_op(0, 1, $urandom_range(0, 255), $urandom_range(0, 127), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed time limit reached, expected test completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
